// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: load-use, EX redirect and
// multi-cycle divide sequencing, plus saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int DIV_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_div_start,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             div_busy,
    output logic             div_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    generate
        if (DIV_LAT < 2) begin : g_bad_div_lat
            $error("pipe_hazard_ctrl: DIV_LAT must be >= 2");
        end
    endgenerate

    localparam int DCNT_W = (DIV_LAT < 2) ? 1 : $clog2(DIV_LAT);
    // The start cycle is the first frozen cycle, so the counter covers the rest.
    localparam logic [DCNT_W-1:0] DCNT_START = DCNT_W'(DIV_LAT - 2);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        DIV_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic load_use_s;
    logic pc_stall_s, ifid_stall_s, ifid_flush_s, idex_stall_s, idex_flush_s;
    logic exmem_flush_s, div_busy_s, div_done_s;

    // Load-use match against a non-zero destination of a load in EX.
    always_comb begin
        load_use_s = 1'b0;
        if (ex_mem_read && (ex_rd != 5'd0)) begin
            load_use_s = (id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd));
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Next-state and stall/flush decode; divide beats redirect beats load-use.
    always_comb begin
        state_d       = state_q;
        dcnt_d        = dcnt_q;
        pc_stall_s    = 1'b0;
        ifid_stall_s  = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_stall_s  = 1'b0;
        idex_flush_s  = 1'b0;
        exmem_flush_s = 1'b0;
        div_busy_s    = 1'b0;
        div_done_s    = 1'b0;
        if (!reset) begin
            state_d = RUN;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_div_start) begin
                        pc_stall_s    = 1'b1;
                        ifid_stall_s  = 1'b1;
                        idex_stall_s  = 1'b1;
                        exmem_flush_s = 1'b1;
                        dcnt_d        = DCNT_START;
                        state_d       = DIV_BUSY;
                    end else if (ex_branch_taken) begin
                        ifid_flush_s = 1'b1;
                        idex_flush_s = 1'b1;
                    end else if (load_use_s) begin
                        pc_stall_s   = 1'b1;
                        ifid_stall_s = 1'b1;
                        idex_flush_s = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                DIV_BUSY: begin
                    div_busy_s = 1'b1;
                    if (dcnt_q != '0) begin
                        pc_stall_s    = 1'b1;
                        ifid_stall_s  = 1'b1;
                        idex_stall_s  = 1'b1;
                        exmem_flush_s = 1'b1;
                        dcnt_d        = dcnt_q - 1'b1;
                    end else begin
                        div_done_s = 1'b1;
                        state_d    = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    dcnt_d  = '0;
                end
            endcase
        end
    end

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!reset) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (pc_stall_s && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (ifid_flush_s && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        dcnt_q      <= dcnt_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign pc_stall    = pc_stall_s;
    assign ifid_stall  = ifid_stall_s;
    assign ifid_flush  = ifid_flush_s;
    assign idex_stall  = idex_stall_s;
    assign idex_flush  = idex_flush_s;
    assign exmem_flush = exmem_flush_s;
    assign div_busy    = div_busy_s;
    assign div_done    = div_done_s;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, random
// stimulus against a behavioural model, and a counter saturation sequence.
module tb_pipe_hazard_ctrl;

    localparam int DIV_LAT = 4;
    localparam int CNT_W   = 16;
    localparam int SAT_W   = 4;
    localparam int NTAB    = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_div_start;

    logic a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_stall, a_idex_flush;
    logic a_exmem_flush, a_div_busy, a_div_done;
    logic [CNT_W-1:0] a_stall_cnt, a_flush_cnt;
    logic s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_stall, s_idex_flush;
    logic s_exmem_flush, s_div_busy, s_div_done;
    logic [SAT_W-1:0] s_stall_cnt, s_flush_cnt;

    pipe_hazard_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_div_start(ex_div_start),
        .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall), .ifid_flush(a_ifid_flush),
        .idex_stall(a_idex_stall), .idex_flush(a_idex_flush), .exmem_flush(a_exmem_flush),
        .div_busy(a_div_busy), .div_done(a_div_done),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_hazard_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(SAT_W)) u_sat (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_div_start(ex_div_start),
        .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall), .ifid_flush(s_ifid_flush),
        .idex_stall(s_idex_stall), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
        .div_busy(s_div_busy), .div_done(s_div_done),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Output vector order: pc_stall, ifid_stall, ifid_flush, idex_stall,
    // idex_flush, exmem_flush, div_busy, div_done.
    logic [7:0] a_out, s_out;
    assign a_out = {a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_stall,
                    a_idex_flush, a_exmem_flush, a_div_busy, a_div_done};
    assign s_out = {s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_stall,
                    s_idex_flush, s_exmem_flush, s_div_busy, s_div_done};

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       bt;
        logic       ds;
        logic [7:0] exp;
    } vec_t;

    vec_t tab [NTAB];

    int errors = 0;
    int checks = 0;
    int illegal_seen = 0;

    // Behavioural model: remaining EX cycles of an in-flight divide and the event counts.
    int div_left = 0;
    int m_stall = 0, m_flush = 0, m_sstall = 0, m_sflush = 0;

    function automatic logic [7:0] model_out();
        logic lu;
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
        if (!reset)            return 8'b0000_0000;
        else if (div_left > 1) return 8'b1101_0110;
        else if (div_left == 1) return 8'b0000_0011;
        else if (ex_div_start) return 8'b1101_0100;
        else if (ex_branch_taken) return 8'b0010_1000;
        else if (lu)           return 8'b1100_1000;
        else                   return 8'b0000_0000;
    endfunction

    function automatic int sat_inc(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_in(input vec_t v);
        reset = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_rd = v.rd; ex_mem_read = v.mr; ex_branch_taken = v.bt; ex_div_start = v.ds;
    endtask

    // Called just after a negedge with inputs applied; checks, clocks, advances the model.
    task automatic do_cycle(input logic use_tab, input logic [7:0] tab_exp, input string tag);
        logic [7:0] mexp;
        logic       rst_now, ds_now;
        #1;
        mexp    = model_out();
        rst_now = reset;
        ds_now  = ex_div_start;
        check({tag, "_outputs"}, int'(a_out), int'(use_tab ? tab_exp : mexp));
        check({tag, "_sat_outputs"}, int'(s_out), int'(use_tab ? tab_exp : mexp));
        check({tag, "_stall_cnt"}, int'(a_stall_cnt), m_stall);
        check({tag, "_flush_cnt"}, int'(a_flush_cnt), m_flush);
        check({tag, "_sat_stall_cnt"}, int'(s_stall_cnt), m_sstall);
        check({tag, "_sat_flush_cnt"}, int'(s_flush_cnt), m_sflush);
        @(posedge clk);
        if (!rst_now) begin
            div_left = 0; m_stall = 0; m_flush = 0; m_sstall = 0; m_sflush = 0;
        end else begin
            if (div_left > 0) div_left--;
            else if (ds_now) div_left = DIV_LAT - 1;
            if (mexp[7]) begin
                m_stall  = sat_inc(m_stall, CNT_W);
                m_sstall = sat_inc(m_sstall, SAT_W);
            end
            if (mexp[5]) begin
                m_flush  = sat_inc(m_flush, CNT_W);
                m_sflush = sat_inc(m_sflush, SAT_W);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        //          rst   rs1   rs2   u1    u2    rd    mr    bt    ds    expected
        tab[0]  = '{1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 8'b0000_0000};
        tab[1]  = '{1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 8'b0000_0000};
        tab[2]  = '{1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 8'b1100_1000};
        tab[3]  = '{1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
        tab[4]  = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'b0000_0000};
        tab[5]  = '{1'b1, 5'd7, 5'd1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 8'b0000_0000};
        tab[6]  = '{1'b1, 5'd7, 5'd1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 8'b1100_1000};
        tab[7]  = '{1'b1, 5'd7, 5'd1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 8'b0010_1000};
        tab[8]  = '{1'b1, 5'd7, 5'd1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 8'b1101_0100};
        tab[9]  = '{1'b1, 5'd7, 5'd1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 8'b1101_0110};
        tab[10] = '{1'b1, 5'd7, 5'd1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 8'b1101_0110};
        tab[11] = '{1'b1, 5'd7, 5'd1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 8'b0000_0011};
        tab[12] = '{1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
        tab[13] = '{1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 8'b1101_0100};
        tab[14] = '{1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
        tab[15] = '{1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 8'b0000_0000};
        tab[16] = '{1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 8'b0000_0000};

        set_in(tab[0]);
        @(negedge clk);

        for (int i = 0; i < NTAB; i++) begin
            set_in(tab[i]);
            do_cycle(1'b1, tab[i].exp, $sformatf("tab%0d", i));
        end

        for (int i = 0; i < 400; i++) begin
            v.rst = ($urandom_range(0, 39) != 0);
            v.rs1 = 5'($urandom_range(0, 3));
            v.rs2 = 5'($urandom_range(0, 3));
            v.u1  = 1'($urandom_range(0, 1));
            v.u2  = 1'($urandom_range(0, 1));
            v.rd  = 5'($urandom_range(0, 3));
            v.mr  = 1'($urandom_range(0, 1));
            v.bt  = ($urandom_range(0, 4) == 0);
            v.ds  = ($urandom_range(0, 7) == 0);
            v.exp = 8'b0000_0000;
            if (v.rst && v.bt && v.ds && (div_left == 0)) illegal_seen++;
            set_in(v);
            do_cycle(1'b0, 8'b0000_0000, $sformatf("rnd%0d", i));
        end
        if (illegal_seen > 0)
            $display("note: div_start with branch_taken applied %0d times (divide takes priority)", illegal_seen);

        v = '{1'b0, 5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 8'b0000_0000};
        set_in(v);
        do_cycle(1'b0, 8'b0000_0000, "sat_rst");
        v.rst = 1'b1;
        set_in(v);
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b0, 8'b0000_0000, $sformatf("sat%0d", i));
        end
        #1;
        check("sat_stall_cnt_final", int'(s_stall_cnt), 15);
        check("wide_stall_cnt_final", int'(a_stall_cnt), 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
